// File: rtl/mult_acc_serializer_if.sv
// -----------------------------------------------------------------------------
// mult_acc_serializer_if
//
// Purpose:
//   Bundles the product intake stream, the byte output stream and the control
//   and status signals of mult_acc_serializer into one interface.
//
// Handshake semantics (both streams):
//   A transfer happens on a rising clock edge where valid and ready are both 1.
//   The sender holds valid and its payload stable until that edge. The
//   receiver may raise or lower ready freely. Neither side makes valid depend
//   combinationally on ready.
//
// Signal summary:
//   clr         master->slave  synchronous clear, highest priority
//   burst_len   master->slave  products per result (0 means 2^CNT_W)
//   prod_valid  master->slave  product available
//   prod        master->slave  8-bit unsigned product
//   prod_ready  slave->master  block can accept a product
//   out_valid   slave->master  out_byte is valid
//   out_ready   master->slave  consumer accepts the byte
//   out_byte    slave->master  result byte (low byte first, then high)
//   out_last    slave->master  marks the high byte
//   overflow    slave->master  sticky wrap flag for the current result
//   dbg_state   slave->master  FSM state for observation
// -----------------------------------------------------------------------------
interface mult_acc_serializer_if #(
    parameter int CNT_W = 4
);
    logic             clr;
    logic [CNT_W-1:0] burst_len;
    logic             prod_valid;
    logic [7:0]       prod;
    logic             prod_ready;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_byte;
    logic             out_last;
    logic             overflow;
    logic [1:0]       dbg_state;

    // The accumulator block itself.
    modport slave (
        input  clr,
        input  burst_len,
        input  prod_valid,
        input  prod,
        input  out_ready,
        output prod_ready,
        output out_valid,
        output out_byte,
        output out_last,
        output overflow,
        output dbg_state
    );

    // Whoever feeds products and consumes the result bytes.
    modport master (
        output clr,
        output burst_len,
        output prod_valid,
        output prod,
        output out_ready,
        input  prod_ready,
        input  out_valid,
        input  out_byte,
        input  out_last,
        input  overflow,
        input  dbg_state
    );
endinterface

// File: rtl/mult_acc_serializer.sv
// -----------------------------------------------------------------------------
// mult_acc_serializer
//
// Purpose:
//   Downstream stage of the 4x4 array multiplier. Sums a programmable burst of
//   1..2^CNT_W unsigned 8-bit products into an ACC_W-bit accumulator. It then
//   sends the sum as two bytes, low byte first, so an 8-pin output bus can
//   carry sums wider than 8 bits.
//
// Parameters:
//   ACC_W  accumulator width, legal range 9..16 (default 12 holds 16*225)
//   CNT_W  burst counter width, maximum burst is 2^CNT_W
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mult_acc_serializer_if.slave (intake, output and status signals)
//
// Behaviour:
//   ACC      prod_ready=1; every accepted product is added modulo 2^ACC_W, and
//            a carry out sets the sticky overflow flag. The burst length is
//            sampled on the first product of a burst.
//   SEND_LO  out_byte = acc[7:0], out_last = 0.
//   SEND_HI  out_byte = acc[ACC_W-1:8] zero-extended, out_last = 1.
//            The handshake on this byte clears acc, cnt and overflow.
//   clr acts like a reset at the next edge and beats any simultaneous
//   handshake.
//   Every output is a register or a decode of the state register, so there is
//   no path from out_ready or prod_valid to any output.
// -----------------------------------------------------------------------------
module mult_acc_serializer #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mult_acc_serializer_if.slave  bus
);

    localparam logic [1:0] ST_ACC     = 2'd0;
    localparam logic [1:0] ST_SEND_LO = 2'd1;
    localparam logic [1:0] ST_SEND_HI = 2'd2;

    // Burst length of 2^CNT_W, used when burst_len is 0.
    localparam logic [CNT_W:0] MAX_LEN = {1'b1, {CNT_W{1'b0}}};

    logic [1:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len_q;
    logic             r_overflow;

    logic [ACC_W:0]   w_sum;
    logic [CNT_W-1:0] w_len_sel;
    logic [CNT_W:0]   w_len_eff;
    logic [CNT_W:0]   w_cnt_next;
    logic             w_burst_done;
    logic [15:0]      w_acc_ext;

    // One extra bit catches the carry out of the accumulator.
    assign w_sum = {1'b0, r_acc} + {{(ACC_W - 7){1'b0}}, bus.prod};

    // The first product of a burst compares against the live burst_len, which
    // is the value being latched on the same edge. Later products compare
    // against the latched copy, so changes to burst_len mid-burst are ignored.
    assign w_len_sel    = (r_cnt == '0) ? bus.burst_len : r_len_q;
    assign w_len_eff    = (w_len_sel == '0) ? MAX_LEN : {1'b0, w_len_sel};
    assign w_cnt_next   = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_burst_done = (w_cnt_next == w_len_eff);

    // Zero-extend to 16 bits so the high byte is always a full 8 bits,
    // whatever ACC_W is.
    assign w_acc_ext = 16'(r_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ACC;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_len_q    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clr) begin
            r_state    <= ST_ACC;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_len_q    <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    // prod_ready is 1 in this state, so valid alone is a transfer.
                    if (bus.prod_valid) begin
                        r_acc <= w_sum[ACC_W-1:0];
                        r_cnt <= w_cnt_next[CNT_W-1:0];
                        if (w_sum[ACC_W]) begin
                            r_overflow <= 1'b1;
                        end
                        if (r_cnt == '0) begin
                            r_len_q <= bus.burst_len;
                        end
                        if (w_burst_done) begin
                            r_state <= ST_SEND_LO;
                        end
                    end
                end
                ST_SEND_LO: begin
                    if (bus.out_ready) begin
                        r_state <= ST_SEND_HI;
                    end
                end
                ST_SEND_HI: begin
                    if (bus.out_ready) begin
                        r_state    <= ST_ACC;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_ACC;
                end
            endcase
        end
    end

    // Outputs decode the state register, and out_byte picks a byte of the
    // accumulator register. In ACC out_byte reads 0x00, which matches its reset value.
    always_comb begin
        bus.prod_ready = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_last   = 1'b0;
        bus.out_byte   = 8'h00;
        case (r_state)
            ST_ACC: begin
                bus.prod_ready = 1'b1;
            end
            ST_SEND_LO: begin
                bus.out_valid = 1'b1;
                bus.out_byte  = w_acc_ext[7:0];
            end
            ST_SEND_HI: begin
                bus.out_valid = 1'b1;
                bus.out_last  = 1'b1;
                bus.out_byte  = w_acc_ext[15:8];
            end
            default: begin
                bus.prod_ready = 1'b0;
            end
        endcase
    end

    assign bus.overflow  = r_overflow;
    assign bus.dbg_state = r_state;

endmodule
